// File: rtl/ysyx_23060278_skid_buf_pkg.sv
// ysyx_23060278_skid_buf_pkg: state codes shared by the NPC pipeline buffers.
package ysyx_23060278_skid_buf_pkg;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/ysyx_23060278_skid_buf_reg.sv
// ysyx_23060278_skid_buf_reg: generic enabled register with synchronous active-high reset.
module ysyx_23060278_skid_buf_reg #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)      q <= RESET_VAL;
        else if (wen) q <= d;
    end

endmodule

// File: rtl/ysyx_23060278_skid_buf.sv
// ysyx_23060278_skid_buf: two-entry valid/ready skid buffer with registered in_ready
// and a saturating stall-cycle counter.
module ysyx_23060278_skid_buf
    import ysyx_23060278_skid_buf_pkg::*;
#(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [1:0]       state_q;
    skid_state_e      state, state_d;
    logic [WIDTH-1:0] main_q, skid_q, main_d;
    logic             main_we, skid_we, in_fire, out_fire;

    assign state     = skid_state_e'(state_q);
    assign out_valid = state_q != SKID_EMPTY;
    assign in_ready  = (state_q != SKID_FULL) & !flush;
    assign occupancy = state_q;
    assign out_data  = main_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    // Draining from FULL promotes the skid entry to the head.
    assign main_d    = (state == SKID_FULL) ? skid_q : in_data;

    always_comb begin
        state_d = state;
        main_we = 1'b0;
        skid_we = 1'b0;
        if (flush) begin
            state_d = SKID_EMPTY;
        end else begin
            case (state)
                SKID_EMPTY: begin
                    state_d = in_fire ? SKID_ONE : SKID_EMPTY;
                    main_we = in_fire;
                end
                SKID_ONE: begin
                    state_d = (in_fire & !out_fire) ? SKID_FULL : (!in_fire & out_fire) ? SKID_EMPTY : SKID_ONE;
                    main_we = in_fire & out_fire;
                    skid_we = in_fire & !out_fire;
                end
                SKID_FULL: begin
                    state_d = out_fire ? SKID_ONE : SKID_FULL;
                    main_we = out_fire;
                end
                default: state_d = SKID_EMPTY;
            endcase
        end
    end

    ysyx_23060278_skid_buf_reg #(.WIDTH(2), .RESET_VAL(SKID_EMPTY)) u_state (
        .clk(clk), .rst(rst), .wen(1'b1), .d(state_d), .q(state_q)
    );

    ysyx_23060278_skid_buf_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
        .clk(clk), .rst(rst), .wen(main_we), .d(main_d), .q(main_q)
    );

    ysyx_23060278_skid_buf_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
        .clk(clk), .rst(rst), .wen(skid_we), .d(in_data), .q(skid_q)
    );

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (out_valid & !out_ready & !flush & (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_ysyx_23060278_skid_buf.sv
// tb_ysyx_23060278_skid_buf: directed and random scoreboard checks of the skid buffer.
module tb_ysyx_23060278_skid_buf;

    localparam int          W     = 64;
    localparam int          CW    = 3;
    localparam logic [W-1:0] RST_V = 64'h0000_0000_DEAD_BEEF;

    logic          clk = 1'b0;
    logic          rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready, out_valid;
    logic [W-1:0]  out_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt;

    logic [W-1:0]  exp_q[$];
    int            exp_stall = 0;
    bit            start = 1'b0, acc = 1'b0;
    int            n_vec = 0, n_err = 0;

    ysyx_23060278_skid_buf #(.WIDTH(W), .RESET_VAL(RST_V), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [W-1:0] act, logic [W-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, req, $time);
        end
    endfunction

    // Monitor: compares the DUT against the queue model, then advances the model.
    initial begin
        int occ;
        forever begin
            @(posedge clk);
            #2;
            if (start) begin
                occ = exp_q.size();
                chk("occupancy", W'(occupancy), W'(occ));
                chk("out_valid", W'(out_valid), W'(occ != 0));
                chk("in_ready", W'(in_ready), W'(occ != 2 && !flush));
                chk("stall_cnt", W'(stall_cnt), W'(exp_stall));
                if (occ != 0) chk("out_data", out_data, exp_q[0]);
                if (rst) begin
                    exp_q.delete();
                    exp_stall = 0;
                    acc = 1'b0;
                end else begin
                    if (occ != 0 && !out_ready && !flush && exp_stall != (1 << CW) - 1) exp_stall++;
                    if (occ != 0 && out_ready) void'(exp_q.pop_front());
                    if (flush) exp_q.delete();
                    acc = in_valid && occ != 2 && !flush;
                end
            end
        end
    end

    task automatic step(input bit iv, input logic [W-1:0] d, input bit ordy, input bit fl, input bit r);
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        #2;
        if (acc) exp_q.push_back(d);
    endtask

    initial begin
        // 1 reset
        step(0, '0, 0, 0, 1);
        step(0, '0, 0, 0, 1);
        start = 1'b1;
        step(0, '0, 0, 0, 0);
        chk("reset_out_data", out_data, RST_V);
        // 2 streaming
        step(1, 64'h11, 1, 0, 0);
        step(1, 64'h22, 1, 0, 0);
        step(1, 64'h33, 1, 0, 0);
        step(0, '0, 1, 0, 0);
        step(0, '0, 1, 0, 0);
        // 3 backpressure
        step(1, 64'hA, 0, 0, 0);
        step(1, 64'hB, 0, 0, 0);
        step(1, 64'hE, 0, 0, 0);
        step(0, '0, 0, 0, 0);
        step(0, '0, 1, 0, 0);
        step(0, '0, 1, 0, 0);
        step(0, '0, 1, 0, 0);
        // 4 flush while FULL
        step(1, 64'h1C, 0, 0, 0);
        step(1, 64'h2C, 0, 0, 0);
        step(1, 64'hC, 0, 1, 0);
        step(0, '0, 1, 0, 0);
        step(0, '0, 1, 0, 0);
        // 5 reset while FULL with a live handshake
        step(1, 64'h51, 0, 0, 0);
        step(1, 64'h52, 0, 0, 0);
        step(1, 64'h53, 1, 0, 1);
        step(0, '0, 1, 0, 0);
        step(0, '0, 1, 0, 0);
        // 6 stall counter saturation
        step(1, 64'h66, 0, 0, 0);
        repeat (10) step(0, '0, 0, 0, 0);
        chk("stall_saturated", W'(stall_cnt), W'(7));
        step(0, '0, 1, 0, 0);
        step(0, '0, 1, 0, 0);
        // random traffic with occasional flush
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 1), {$urandom, $urandom}, $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0, 0);
        repeat (4) step(0, '0, 1, 0, 0);
        chk("drained", W'(exp_q.size()), W'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
